// File: rtl/load_scheduler_if.sv
//------------------------------------------------------------------------------
// Module      : load_scheduler_if
// Description : Request/grant bundle between a load controller and the
//               load_scheduler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface load_scheduler_if;
  logic [3:0] req;
  logic       fire;
  logic [3:0] grant;
  logic [2:0] busy_cnt;
  logic       wait_flag;
  logic       emerg;

  modport master (
    output req,
    output fire,
    input  grant,
    input  busy_cnt,
    input  wait_flag,
    input  emerg
  );

  modport slave (
    input  req,
    input  fire,
    output grant,
    output busy_cnt,
    output wait_flag,
    output emerg
  );
endinterface

`default_nettype wire

// File: rtl/load_scheduler.sv
//------------------------------------------------------------------------------
// Module      : load_scheduler
// Description : Round-robin scheduler for four loads (heat, cool, pump,
//               sprinkler) with a concurrency limit, run-time budget,
//               heat/cool exclusion and a fire emergency override.
//               Define LOAD_SCHEDULER_FIRE_EN to enable the fire override.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_scheduler #(
  parameter int MAX_ON  = 2,
  parameter int MAX_RUN = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  load_scheduler_if.slave    bus
);

  localparam logic [2:0] C_MAX_ON  = 3'(MAX_ON);
  localparam logic [4:0] C_MAX_RUN = 5'(MAX_RUN);
  localparam logic [3:0] C_EMERG_GRANT = 4'b1000;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_EMERG = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_grant;
  logic [3:0]  w_grant_nxt;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  w_rr_ptr_nxt;
  logic [4:0]  r_run_cnt [4];
  logic [4:0]  w_run_cnt_nxt [4];
  logic [2:0]  r_busy_cnt;
  logic [2:0]  w_busy_nxt;
  logic        r_wait_flag;
  logic        w_wait_nxt;
  logic        r_emerg;
  logic        w_fire;

  logic [3:0]  w_waiting;
  logic [3:0]  w_force;
  logic [3:0]  w_keep;
  logic [3:0]  w_scan;
  logic [1:0]  w_scan_last;
  logic        w_scan_any;

`ifdef LOAD_SCHEDULER_FIRE_EN
  assign w_fire = bus.fire;
`else
  logic unused_fire;
  assign unused_fire = bus.fire;
  assign w_fire      = 1'b0;
`endif

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  assign w_waiting = bus.req & ~r_grant;

  // A load at its budget yields only when some other load is actually waiting.
  always_comb begin
    w_force = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_force[i] = r_grant[i] && (r_run_cnt[i] == C_MAX_RUN) &&
                   |(w_waiting & ~(4'b0001 << i));
    end
  end

  assign w_keep = r_grant & bus.req & ~w_force;

  // Released loads still have r_grant set, so w_waiting already excludes them.
  always_comb begin
    logic [2:0] slots;
    logic       heat_held;
    logic       cool_held;
    logic [1:0] idx;
    w_scan      = w_keep;
    w_scan_last = r_rr_ptr;
    w_scan_any  = 1'b0;
    slots       = C_MAX_ON - popcount4(w_keep);
    heat_held   = w_keep[0];
    cool_held   = w_keep[1];
    for (int k = 0; k < 4; k++) begin
      idx = r_rr_ptr + 2'(k);
      if ((slots != 3'd0) && w_waiting[idx] &&
          !((idx == 2'd0) && cool_held) && !((idx == 2'd1) && heat_held)) begin
        w_scan[idx] = 1'b1;
        slots       = slots - 3'd1;
        w_scan_last = idx;
        w_scan_any  = 1'b1;
        if (idx == 2'd0) heat_held = 1'b1;
        if (idx == 2'd1) cool_held = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_RUN: begin
        if (w_fire) begin
          w_state_nxt = ST_EMERG;
          w_grant_nxt = C_EMERG_GRANT;
        end else begin
          w_grant_nxt = w_scan;
          if (w_scan_any) w_rr_ptr_nxt = w_scan_last + 2'd1;
        end
      end
      ST_EMERG: begin
        if (w_fire) begin
          w_grant_nxt = C_EMERG_GRANT;
        end else begin
          w_state_nxt = ST_RUN;
          w_grant_nxt = 4'b0000;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_grant_nxt = 4'b0000;
      end
    endcase

    for (int i = 0; i < 4; i++) begin
      if ((w_state_nxt == ST_EMERG) || !w_grant_nxt[i]) begin
        w_run_cnt_nxt[i] = 5'd0;
      end else if (!r_grant[i]) begin
        w_run_cnt_nxt[i] = 5'd1;
      end else if (r_run_cnt[i] >= C_MAX_RUN) begin
        w_run_cnt_nxt[i] = C_MAX_RUN;
      end else begin
        w_run_cnt_nxt[i] = r_run_cnt[i] + 5'd1;
      end
    end

    w_busy_nxt = popcount4(w_grant_nxt);
    w_wait_nxt = |(bus.req & ~w_grant_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_grant     <= 4'b0000;
      r_rr_ptr    <= 2'd0;
      r_busy_cnt  <= 3'd0;
      r_wait_flag <= 1'b0;
      r_emerg     <= 1'b0;
      for (int i = 0; i < 4; i++) r_run_cnt[i] <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_busy_cnt  <= w_busy_nxt;
      r_wait_flag <= w_wait_nxt;
      r_emerg     <= (w_state_nxt == ST_EMERG);
      for (int i = 0; i < 4; i++) r_run_cnt[i] <= w_run_cnt_nxt[i];
    end
  end

  assign bus.grant     = r_grant;
  assign bus.busy_cnt  = r_busy_cnt;
  assign bus.wait_flag = r_wait_flag;
  assign bus.emerg     = r_emerg;

endmodule

`default_nettype wire

// File: tb/tb_load_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_load_scheduler
// Description : Self-checking bench for load_scheduler (MAX_ON=2, MAX_RUN=16)
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_scheduler;

  localparam int MAX_ON  = 2;
  localparam int MAX_RUN = 16;
`ifdef LOAD_SCHEDULER_FIRE_EN
  localparam bit FIRE_EN = 1'b1;
`else
  localparam bit FIRE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  load_scheduler_if bus ();

  load_scheduler #(
    .MAX_ON  (MAX_ON),
    .MAX_RUN (MAX_RUN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  bit [3:0] m_grant;
  int       m_cnt [4];
  int       m_rr;
  bit       m_emerg;
  bit [2:0] m_busy;
  bit       m_wait;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit [3:0] req, input bit fire);
    bit [3:0] nxt;
    int       free;
    int       last;
    int       i;
    bit       got;
    bit       other_wait;
    nxt = 4'b0000;
    if (rst) begin
      m_rr    = 0;
      m_emerg = 1'b0;
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
    end else if (FIRE_EN && fire) begin
      nxt     = 4'b1000;
      m_emerg = 1'b1;
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
    end else if (m_emerg) begin
      m_emerg = 1'b0;
      for (int n = 0; n < 4; n++) m_cnt[n] = 0;
    end else begin
      free = MAX_ON;
      got  = 1'b0;
      last = 0;
      for (int n = 0; n < 4; n++) begin
        if (m_grant[n] && req[n]) begin
          other_wait = 1'b0;
          for (int j = 0; j < 4; j++)
            if (j != n && req[j] && !m_grant[j]) other_wait = 1'b1;
          if (!(m_cnt[n] == MAX_RUN && other_wait)) begin
            nxt[n] = 1'b1;
            free--;
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        i = (m_rr + k) % 4;
        if (free > 0 && req[i] && !m_grant[i] &&
            !(i == 0 && nxt[1]) && !(i == 1 && nxt[0])) begin
          nxt[i] = 1'b1;
          free--;
          last = i;
          got  = 1'b1;
        end
      end
      if (got) m_rr = (last + 1) % 4;
      for (int n = 0; n < 4; n++) begin
        if (!nxt[n])          m_cnt[n] = 0;
        else if (!m_grant[n]) m_cnt[n] = 1;
        else                  m_cnt[n] = (m_cnt[n] < MAX_RUN) ? m_cnt[n] + 1 : MAX_RUN;
      end
    end
    m_grant = nxt;
    m_busy  = 3'($countones(nxt));
    m_wait  = rst ? 1'b0 : |(req & ~nxt);
  endtask

  task automatic step(input bit [3:0] req, input bit fire, input bit rst);
    reset    = rst;
    bus.req  = req;
    bus.fire = fire;
    model_step(rst, req, fire);
    @(posedge clk);
    #1;
    check("grant",     32'(bus.grant),     32'(m_grant));
    check("busy_cnt",  32'(bus.busy_cnt),  32'(m_busy));
    check("wait_flag", 32'(bus.wait_flag), 32'(m_wait));
    check("emerg",     32'(bus.emerg),     32'(m_emerg));
  endtask

  initial begin
    bit [3:0] r_req;
    bit       r_fire;
    bit       r_rst;
    m_grant  = 4'b0000;
    reset    = 1'b1;
    bus.req  = 4'b0000;
    bus.fire = 1'b0;

    // Reset state
    step(4'b1111, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy",  32'(bus.busy_cnt), 32'h0);

    // Two compatible loads granted together
    step(4'b0101, 1'b0, 1'b0);
    check("d_0101_grant", 32'(bus.grant), 32'h5);
    check("d_0101_busy",  32'(bus.busy_cnt), 32'h2);
    check("d_0101_wait",  32'(bus.wait_flag), 32'h0);

    // Drop releases next cycle
    step(4'b0100, 1'b0, 1'b0);
    check("d_drop_grant", 32'(bus.grant), 32'h4);
    step(4'b0000, 1'b0, 1'b0);
    check("d_idle_grant", 32'(bus.grant), 32'h0);
    check("d_idle_busy",  32'(bus.busy_cnt), 32'h0);

    // All request: heat/cool exclusion, then budget force-release
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    check("d_all_grant", 32'(bus.grant), 32'h5);
    check("d_all_wait",  32'(bus.wait_flag), 32'h1);
    repeat (15) step(4'b1111, 1'b0, 1'b0);
    check("d_budget_hold", 32'(bus.grant), 32'h5);
    step(4'b1111, 1'b0, 1'b0);
    check("d_force_grant", 32'(bus.grant), 32'ha);

    // Fire while loads run
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
`ifdef LOAD_SCHEDULER_FIRE_EN
    check("d_fire_grant", 32'(bus.grant), 32'h8);
    check("d_fire_emerg", 32'(bus.emerg), 32'h1);
`else
    check("d_nofire_grant", 32'(bus.grant), 32'h5);
    check("d_nofire_emerg", 32'(bus.emerg), 32'h0);
`endif
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
`ifdef LOAD_SCHEDULER_FIRE_EN
    check("d_exit_grant", 32'(bus.grant), 32'h0);
`endif
    step(4'b0101, 1'b0, 1'b0);
    check("d_resched_grant", 32'(bus.grant), 32'h5);

    // Reset during emergency, fire still high afterwards
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b1);
    check("d_rst_emerg_grant", 32'(bus.grant), 32'h0);
    check("d_rst_emerg_emerg", 32'(bus.emerg), 32'h0);
    step(4'b0101, 1'b1, 1'b0);
`ifdef LOAD_SCHEDULER_FIRE_EN
    check("d_reenter_emerg", 32'(bus.emerg), 32'h1);
`else
    check("d_ignore_fire", 32'(bus.grant), 32'h5);
`endif

    // Randomized traffic against the model
    step(4'b0000, 1'b0, 1'b1);
    r_req  = 4'b0000;
    r_fire = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) r_req = 4'($urandom);
      if (r_fire) r_fire = ($urandom_range(0, 3) != 0);
      else        r_fire = ($urandom_range(0, 39) == 0);
      r_rst = ($urandom_range(0, 149) == 0);
      step(r_req, r_fire, r_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
